// File: rtl/mem_stage_req.sv
// Memory-access pipeline stage (EXE -> WB) on a req/addr_ok/data_ok data bus.
// Optional MEM_ALIGN_CHECK_EN: flag misaligned accesses instead of truncating the address.
module mem_stage_req #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DISC_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                exe_valid,
  output logic                mem_allowin,
  input  logic                exe_is_load,
  input  logic                exe_is_store,
  input  logic [1:0]          exe_size,
  input  logic                exe_unsigned,
  input  logic [ADDR_W-1:0]   exe_vaddr,
  input  logic [DATA_W-1:0]   exe_wdata,
  input  logic [DATA_W-1:0]   exe_result,
  input  logic [4:0]          exe_wnum,
  input  logic [31:0]         exe_pc,
  input  logic                flush,
  input  logic                wb_allowin,
  output logic                mem_valid,
  output logic [DATA_W-1:0]   mem_wbdata,
  output logic [4:0]          mem_wnum,
  output logic [31:0]         mem_pc,
  output logic                mem_wen,
  output logic                mem_exc,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W/8-1:0] data_wstrb,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam logic [DISC_W-1:0] DISC_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t              state, state_nx;
  logic [DISC_W-1:0]   disc_cnt;
  logic                is_load_r, is_store_r, uns_r, exc_r, wen_r;
  logic [1:0]          size_r;
  logic [ADDR_W-1:0]   paddr_r;
  logic [DATA_W-1:0]   wdata_r, wbdata_r;
  logic [4:0]          wnum_r;
  logic [31:0]         pc_r;

  logic                valid_r, exe_is_mem, exe_misal, capture;
  logic                ack_ok, disc_inc, disc_dec;
  logic [2:0]          low_mask;
  logic [ADDR_W-1:0]   vmapped, exe_paddr;
  logic [OW-1:0]       off;
  logic [DATA_W-1:0]   shifted, load_ext;
  logic [NB-1:0]       size_strb;
  logic                sbit;
  int                  nbits;

  assign exe_is_mem = exe_is_load | exe_is_store;

  always_comb begin
    case (exe_size)
      2'd0:    low_mask = 3'b000;
      2'd1:    low_mask = 3'b001;
      2'd2:    low_mask = 3'b011;
      default: low_mask = 3'b111;
    endcase
  end

  generate
    if (ADDR_W == 32) begin : g_map
      // kseg0/kseg1 fold onto the bottom 512 MB of physical space
      assign vmapped = (exe_vaddr[31:30] == 2'b10) ? {3'b000, exe_vaddr[28:0]} : exe_vaddr;
    end else begin : g_nomap
      assign vmapped = exe_vaddr;
    end
  endgenerate

`ifdef MEM_ALIGN_CHECK_EN
  assign exe_misal = exe_is_mem && ((exe_vaddr[2:0] & low_mask) != 3'b000);
  assign exe_paddr = vmapped;
`else
  assign exe_misal = 1'b0;
  assign exe_paddr = vmapped & ~ADDR_W'(low_mask);
`endif

  assign valid_r     = (state != S_IDLE);
  assign mem_allowin = (!valid_r || (mem_valid && wb_allowin)) &&
                       !((disc_cnt != '0) && exe_is_mem);
  assign capture     = exe_valid && mem_allowin && !flush;

  // A data_ok in WAIT with no orphans outstanding belongs to this instruction,
  // so a simultaneous flush consumes it rather than orphaning a new one.
  assign ack_ok   = data_data_ok && (disc_cnt == '0);
  assign disc_dec = data_data_ok && (disc_cnt != '0);
  assign disc_inc = flush && (((state == S_REQ) && data_addr_ok) ||
                              ((state == S_WAIT) && !ack_ok));

  always_comb begin
    state_nx  = state;
    data_req  = 1'b0;
    mem_valid = 1'b0;
    case (state)
      S_IDLE: if (capture) state_nx = (exe_is_mem && !exe_misal) ? S_REQ : S_DONE;
      S_REQ: begin
        data_req = 1'b1;
        if (flush)             state_nx = S_IDLE;
        else if (data_addr_ok) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (flush)       state_nx = S_IDLE;
        else if (ack_ok) state_nx = S_DONE;
      end
      S_DONE: begin
        mem_valid = 1'b1;
        if (flush)           state_nx = S_IDLE;
        else if (wb_allowin) state_nx = capture ? ((exe_is_mem && !exe_misal) ? S_REQ : S_DONE)
                                                : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Bus-side request shaping
  assign off = paddr_r[OW-1:0];

  always_comb begin
    for (int i = 0; i < NB; i++) size_strb[i] = (i < (1 << size_r));
  end

  assign data_wr    = data_req && is_store_r;
  assign data_wstrb = data_wr ? (size_strb << off) : '0;
  assign data_size  = size_r;
  assign data_addr  = paddr_r;

  always_comb begin
    case (size_r)
      2'd0:    data_wdata = {NB{wdata_r[7:0]}};
      2'd1:    data_wdata = {(NB/2){wdata_r[15:0]}};
      2'd2:    data_wdata = {(NB/4){wdata_r[31:0]}};
      default: data_wdata = wdata_r;
    endcase
  end

  // Load alignment and extension
  always_comb begin
    shifted = data_rdata >> {off, 3'b000};
    nbits   = 8 << size_r;
    if (nbits > DATA_W) nbits = DATA_W;
    case (size_r)
      2'd0:    sbit = shifted[7];
      2'd1:    sbit = shifted[15];
      2'd2:    sbit = shifted[31];
      default: sbit = shifted[DATA_W-1];
    endcase
    for (int i = 0; i < DATA_W; i++)
      load_ext[i] = (i < nbits) ? shifted[i] : (sbit & ~uns_r);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      disc_cnt   <= '0;
      is_load_r  <= 1'b0;
      is_store_r <= 1'b0;
      uns_r      <= 1'b0;
      exc_r      <= 1'b0;
      wen_r      <= 1'b0;
      size_r     <= 2'd0;
      paddr_r    <= '0;
      wdata_r    <= '0;
      wbdata_r   <= '0;
      wnum_r     <= 5'd0;
      pc_r       <= 32'd0;
    end else begin
      state <= state_nx;
      if (disc_inc && !disc_dec && (disc_cnt != DISC_MAX)) disc_cnt <= disc_cnt + 1'b1;
      else if (disc_dec && !disc_inc)                      disc_cnt <= disc_cnt - 1'b1;
      if (capture) begin
        is_load_r  <= exe_is_load;
        is_store_r <= exe_is_store;
        uns_r      <= exe_unsigned;
        exc_r      <= exe_misal;
        size_r     <= exe_size;
        paddr_r    <= exe_paddr;
        wdata_r    <= exe_wdata;
        wnum_r     <= exe_wnum;
        pc_r       <= exe_pc;
        wbdata_r   <= exe_misal ? DATA_W'(exe_vaddr) : exe_result;
        wen_r      <= !exe_misal && (exe_is_load || (!exe_is_store && exe_wnum != 5'd0));
      end else if ((state == S_WAIT) && ack_ok && !flush && is_load_r) begin
        wbdata_r <= load_ext;
      end
    end
  end

  assign mem_wbdata = wbdata_r;
  assign mem_wnum   = wnum_r;
  assign mem_pc     = pc_r;
  assign mem_wen    = mem_valid && wen_r;
  assign mem_exc    = mem_valid && exc_r;

endmodule

// File: doc/mem_stage_req.md
Name: mem_stage_req

Overview:
- Parametrised memory-access pipeline stage. Sits between EXE and WB.
- Replaces the single-cycle SRAM access with a request/response data bus (req/addr_ok/data_ok), so the stage tolerates variable memory latency.
- Performs load byte/half/word alignment and sign/zero extension internally.
- Tracks responses from flushed instructions and discards them, so a flush never corrupts a later access.

Parameters:
- DATA_W, 32, data bus width; must be 32 or 64; byte lanes NB = DATA_W/8.
- ADDR_W, 32, address width.
- DISC_W, 2, width of the discard counter; at most 2^DISC_W-1 orphaned responses are tracked.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- exe_valid  in  1  EXE holds a valid instruction
- mem_allowin  out  1  stage can accept an instruction this cycle
- exe_is_load  in  1  instruction is a load
- exe_is_store  in  1  instruction is a store
- exe_size  in  2  access size: 0=byte, 1=half, 2=word, 3=dword (dword legal only when DATA_W=64)
- exe_unsigned  in  1  zero-extend the load result
- exe_vaddr  in  ADDR_W  virtual address
- exe_wdata  in  DATA_W  store data, LSB-aligned
- exe_result  in  DATA_W  ALU result for non-memory instructions
- exe_wnum  in  5  destination register number
- exe_pc  in  32  PC
- flush  in  1  kill the instruction held in the stage
- wb_allowin  in  1  WB can accept
- mem_valid  out  1  stage output valid
- mem_wbdata  out  DATA_W  writeback data
- mem_wnum  out  5  destination register number
- mem_pc  out  32  PC
- mem_wen  out  1  register write enable
- mem_exc  out  1  alignment exception flag (tied 0 when the optional feature is compiled out)
- data_req  out  1  bus request
- data_wr  out  1  1 = write request
- data_size  out  2  request size
- data_addr  out  ADDR_W  physical address
- data_wstrb  out  NB  byte-lane write strobes
- data_wdata  out  DATA_W  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response or write acknowledge
- data_rdata  in  DATA_W  read data

Behaviour:
- Reset: state=IDLE, valid_r=0, discard counter=0. All outputs 0: mem_valid, data_req, data_wr, data_wstrb, mem_wen, mem_exc.
- Payload registers are captured when mem_allowin && exe_valid.
- mem_allowin = !valid_r || (mem_valid && wb_allowin). It is also 0 whenever the discard counter is nonzero and the incoming instruction is a memory access.
- Address mapping:
  - vaddr[31:30]==2'b10 (kseg0/kseg1): paddr = {3'b000, vaddr[28:0]}.
  - Otherwise paddr = vaddr.
  - When ADDR_W != 32, the address passes through unmapped.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on capture, a memory access goes to REQ; any other instruction goes to DONE with mem_wbdata = exe_result.
  - REQ: data_req=1, and address, size, strobes and data are held stable until data_addr_ok. On data_req && data_addr_ok, go to WAIT. data_ok never arrives in the same cycle as addr_ok.
  - WAIT: on data_data_ok with discard counter == 0:
    - Loads latch the aligned, extended rdata.
    - Go to DONE.
  - DONE: mem_valid=1. On wb_allowin, go to IDLE, or straight to REQ/DONE when a new instruction is captured in the same cycle.
- Store strobes: size-based mask shifted left by paddr[log2(NB)-1:0]. wdata is replicated across the bus for size < full width.
- Load extraction:
  - rdata is shifted right by 8*offset and masked to the access size.
  - Sign-extended from the top bit unless exe_unsigned is set.
  - mem_wen=1 for loads and for non-store instructions with wnum != 0.
- Flush:
  - In REQ before addr_ok: drop the instruction immediately. data_req falls the next cycle; the bus permits this.
  - In REQ on the same cycle as addr_ok, or in WAIT: discard counter += 1, state goes to IDLE.
  - In DONE: drop the instruction.
  - flush has priority over capture in the same cycle.
- Discard counter:
  - Decrements on each data_data_ok while nonzero; that response is ignored.
  - Increment and decrement in the same cycle leave it unchanged.
  - It saturates: no increment at max. This cannot occur when flushes are spaced by at least one request.
- Reset mid-operation: all state is cleared immediately; outstanding bus responses are not tracked after reset.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - Misaligned accesses are detected: half with addr[0]!=0, word with addr[1:0]!=0, dword with addr[2:0]!=0.
  - Such an access never issues a request; it goes directly to DONE with mem_exc=1 and mem_wen=0.
  - mem_wbdata carries the bad vaddr.
- Undefined: mem_exc is tied 0, and the low address bits below the access size are forced to zero.

Test Plan:
- lw at vaddr 0x80001004, addr_ok after 2 cycles, data_ok 3 cycles later with rdata 0xDEADBEEF -> data_addr=0x00001004; mem_valid rises the cycle after data_ok; mem_wbdata=0xDEADBEEF.
- lb at offset 3 with rdata 0x80112233 -> mem_wbdata=0xFFFFFF80; lbu at offset 3 -> 0x00000080; lh at offset 2 -> 0xFFFF8011.
- sh at 0x00000102 with wdata 0x0000ABCD -> data_wstrb=4'b1100, data_wdata=0xABCDABCD, data_wr=1; no register write.
- Flush during WAIT, then a new lw is presented -> allowin stays low until the orphaned data_ok; the new request's data_ok returns its own rdata.
- wb_allowin held 0 for 4 cycles in DONE -> mem_valid and mem_wbdata stable, no new data_req.
- With MEM_ALIGN_CHECK_EN, lw at 0x00000002 -> no data_req; mem_exc=1, mem_wbdata=0x00000002, mem_wen=0.
